angle_reducer: RTL and testbench

//  Iterative range-reduction stage placed directly upstream of the CORDIC rotator.
//  - Accepts an arbitrary angle in radians.
//  - Subtracts or adds pi/2 (and, optionally, 2pi) until the residue lies in [-pi/4, +pi/4].
//  - Emits the residue in the rotator's angle scaling (Q1.31, pi/4 = 0x6487ED51).
//  - Emits a 2-bit quadrant code, which downstream uses to swap and negate sin/cos.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/angred_step.sv | 48 ++++
 rtl/angle_reducer.sv | 108 ++++++++++
 tb/tb_angle_reducer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the angle reducer and the CORDIC rotator.
//  - Widths: input angle Q3.28, output residue Q1.31, accumulator Q3.31.
//  - Angle constants are at accumulator scaling (Q3.31), truncated.
//    PI_2 is exactly 2*PI_4 and TWO_PI is exactly 4*PI_2, so the coarse 2pi
//    step and four pi/2 steps leave identical residues.
//  - state_e: reducer FSM states.
package cordic_pkg;

    localparam int W_IN  = 32;
    localparam int W_OUT = 32;
    localparam int W_ACC = 35;
    localparam int W_K   = 4;

    localparam logic signed [W_ACC-1:0] PI_4   = 35'sh0_6487_ED51;
    localparam logic signed [W_ACC-1:0] PI_2   = 35'sh0_C90F_DAA2;
    localparam logic signed [W_ACC-1:0] TWO_PI = 35'sh3_243F_6A88;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/angred_step.sv
// One combinational range-reduction step.
//  acc_i      : current accumulator, Q3.31
//  k_i        : current signed quarter-turn count
//  acc_o      : accumulator after this step
//  k_o        : count after this step
//  in_range_o : acc_i already lies in [-PI_4, +PI_4]; no adjustment made
// Optional build macro ANGLE_REDUCER_COARSE_EN: a whole turn (2pi) is removed
// first while |acc| >= TWO_PI, leaving k unchanged (a full turn does not move
// the quadrant).
module angred_step
    import cordic_pkg::*;
(
    input  logic signed [W_ACC-1:0] acc_i,
    input  logic signed [W_K-1:0]   k_i,
    output logic signed [W_ACC-1:0] acc_o,
    output logic signed [W_K-1:0]   k_o,
    output logic                    in_range_o
);

    logic coarse_hit;

    always_comb begin
`ifdef ANGLE_REDUCER_COARSE_EN
        coarse_hit = (acc_i >= TWO_PI) || (acc_i <= -TWO_PI);
`else
        coarse_hit = 1'b0;
`endif
    end

    always_comb begin
        acc_o      = acc_i;
        k_o        = k_i;
        in_range_o = 1'b0;
        if (coarse_hit) begin
            acc_o = acc_i[W_ACC-1] ? (acc_i + TWO_PI) : (acc_i - TWO_PI);
        end else if (acc_i > PI_4) begin
            acc_o = acc_i - PI_2;
            k_o   = k_i + 4'sd1;
        end else if (acc_i < -PI_4) begin
            acc_o = acc_i + PI_2;
            k_o   = k_i - 4'sd1;
        end else begin
            // Strict comparisons: exactly +/-PI_4 is already in range.
            in_range_o = 1'b1;
        end
    end

endmodule

// File: rtl/angle_reducer.sv
// Iterative range reduction ahead of the CORDIC rotator.
// Folds an angle (Q3.28, [-8, 8) rad) into a residue |r| <= pi/4 (Q1.31)
// plus a quadrant code k mod 4, one pi/2 step per cycle.
// Optional build macro ANGLE_REDUCER_COARSE_EN enables a 2pi pre-step
// (see angred_step); out_quad is the same either way.
// Ports:
//  clk        clock; all state updates on the falling edge
//  reset_n    synchronous active-low reset, sampled on the falling edge
//  in_valid   input angle valid
//  in_ready   block can accept an angle (IDLE only)
//  in_rad     input angle, Q3.28
//  out_valid  residue/quadrant valid, held until consumed
//  out_ready  downstream accepts the result
//  out_rad    residue, Q1.31
//  out_quad   k mod 4
//  dbg_state  current FSM state (state_e encoding)
// Handshake: a transfer happens on a falling edge where valid and ready are
// both high; valid, once raised, holds with its data stable until that edge,
// and ready never depends on valid.
module angle_reducer
    import cordic_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_rad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_rad,
    output logic [1:0]       out_quad,
    output logic [1:0]       dbg_state
);

    state_e                  state_q, state_d;
    logic signed [W_ACC-1:0] acc_q, acc_d;
    logic signed [W_K-1:0]   k_q, k_d;
    logic [W_OUT-1:0]        out_rad_q, out_rad_d;
    logic [1:0]              out_quad_q, out_quad_d;

    logic signed [W_ACC-1:0] step_acc;
    logic signed [W_K-1:0]   step_k;
    logic                    step_in_range;

    angred_step u_step (
        .acc_i      (acc_q),
        .k_i        (k_q),
        .acc_o      (step_acc),
        .k_o        (step_k),
        .in_range_o (step_in_range)
    );

    always_ff @(negedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            k_q        <= '0;
            out_rad_q  <= '0;
            out_quad_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            out_rad_q  <= out_rad_d;
            out_quad_q <= out_quad_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        k_d        = k_q;
        out_rad_d  = out_rad_q;
        out_quad_d = out_quad_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Q3.28 -> Q3.31: the accumulator is exactly 3 bits wider.
                    acc_d   = {in_rad, 3'b000};
                    k_d     = '0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                acc_d = step_acc;
                k_d   = step_k;
                if (step_in_range) begin
                    // |acc| <= PI_4 here, so the low 32 bits hold it losslessly.
                    out_rad_d  = acc_q[W_OUT-1:0];
                    out_quad_d = k_q[1:0];
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by reset_n so nothing is offered while reset is being held.
    assign in_ready  = reset_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_rad   = out_rad_q;
    assign out_quad  = out_quad_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_angle_reducer.sv
module tb_angle_reducer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rad;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rad;
  logic [1:0]  out_quad;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  angle_reducer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rad    (in_rad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rad   (out_rad),
    .out_quad  (out_quad),
    .dbg_state (dbg_state)
  );

  // cycle count advances on the active (falling) edge
  int cyc = 0;
  always @(negedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] rad;
    logic [1:0]  quad;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Smallest |k| such that x - k*pi/2 lies in [-pi/4, pi/4] (closed form).
  function automatic longint k_for(input longint x);
    longint p4, p2;
    p4 = 64'sh6487ED51;
    p2 = 64'shC90FDAA2;
    if (x > p4)       return (x - p4 + p2 - 1) / p2;
    else if (x < -p4) return -((-x - p4 + p2 - 1) / p2);
    else              return 0;
  endfunction

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model(input logic [31:0] a, output logic [31:0] r,
                                output logic [1:0] q, output int lat);
    longint x, k, res, p2, two;
    p2  = 64'shC90FDAA2;
    two = 64'sh3243F6A88;
    x   = longint'($signed(a)) * 8;
    k   = k_for(x);
    res = x - k * p2;
    r   = res[31:0];
    q   = k[1:0];
    lat = int'(labs(k)) + 1;
`ifdef ANGLE_REDUCER_COARSE_EN
    if (x >= two || x <= -two) begin
      longint xc;
      xc  = (x >= 0) ? x - two : x + two;
      lat = int'(labs(k_for(xc))) + 2;
    end
`endif
  endfunction

  // ---------------- compare process ----------------
  logic prev_valid = 1'b0;
  always @(posedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        check("out_rad", out_rad, exp_q[0].rad);
        check("out_quad", out_quad, exp_q[0].quad);
        if (!prev_valid) check("latency", cyc - exp_q[0].acc_cyc, exp_q[0].lat);
      end
    end
    prev_valid <= (reset_n === 1'b1) && (out_valid === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic accept(input logic [31:0] a);
    logic [31:0] r;
    logic [1:0]  q;
    int          lat;
    bit          ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      ok = (in_ready === 1'b1);
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_rad   = a;
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    model(a, r, q, lat);
    exp_q.push_back('{r, q, lat, cyc});
  endtask

  task automatic complete(input int hold, input bit pulse);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      seen = (out_valid === 1'b1);
    end
    if (!seen) begin
      check("out_valid_timeout", 0, 1);
      exp_q.delete();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      check("in_ready_in_done", in_ready, 0);
      check("out_valid_hold", out_valid, 1);
      if (pulse) begin
        in_valid = 1'b1;
        in_rad   = $urandom;
      end
      @(negedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    out_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic pin_model(input string name, input logic [31:0] a,
                           input logic [31:0] er, input logic [1:0] eq, input int el);
    logic [31:0] r;
    logic [1:0]  q;
    int          lat;
    model(a, r, q, lat);
    check({name, "_rad"}, r, er);
    check({name, "_quad"}, q, eq);
    check({name, "_lat"}, lat, el);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int lat_8rad;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_rad    = '0;

`ifdef ANGLE_REDUCER_COARSE_EN
    lat_8rad = 3;
`else
    lat_8rad = 6;
`endif
    // hand-computed literals pinning the model
    pin_model("m_zero",   32'h0000_0000, 32'h0000_0000, 2'd0, 1);
    pin_model("m_pi2",    32'h1921_FB54, 32'hFFFF_FFFE, 2'd1, 2);
    pin_model("m_negpi",  32'hCDBC_0958, 32'h0000_0004, 2'd2, 3);
    pin_model("m_8rad",   32'h7FFF_FFFF, 32'h12B0_BACE, 2'd1, lat_8rad);
    pin_model("m_pi4",    32'h0C90_FDAA, 32'h6487_ED50, 2'd0, 1);
    pin_model("m_pi4p1",  32'h0C90_FDAB, 32'h9B78_12B6, 2'd1, 2);

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("in_ready_during_reset", in_ready, 0);
    reset_n = 1'b1;
    @(posedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_rad", out_rad, 0);
    check("rst_out_quad", out_quad, 0);

    // directed angles
    accept(32'h0000_0000); complete(0, 1'b0);
    accept(32'h1921_FB54); complete(1, 1'b0);
    accept(32'hCDBC_0958); complete(0, 1'b0);
    accept(32'h7FFF_FFFF); complete(2, 1'b0);
    accept(32'h8000_0000); complete(0, 1'b0);
    accept(32'h0C90_FDAA); complete(0, 1'b0);
    accept(32'hF36F_0256); complete(0, 1'b0);
    accept(32'h0C90_FDAB); complete(0, 1'b0);
    accept(32'hF36F_0255); complete(0, 1'b0);

    // hold in DONE for 5 cycles with ignored input pulses
    accept(32'h2D97_C7F3); complete(5, 1'b1);

    // reset mid-REDUCE drops the transaction
    accept(32'h7FFF_FFFF);
    @(posedge clk);
    @(posedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_rad", out_rad, 0);
    check("midrst_out_quad", out_quad, 0);
    accept(32'h7FFF_FFFF); complete(0, 1'b0);

    // randomized angles: full range and near quadrant boundaries
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      int          m;
      if ($urandom_range(0, 2) == 0) begin
        m = int'($urandom_range(0, 20)) - 10;
        a = 32'(m * 210828714 + int'($urandom_range(0, 4)) - 2);
      end else begin
        a = $urandom;
      end
      accept(a);
      complete(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
